// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor. One full-adder cell and a registered carry
// process the operands LSB first, one bit per clock. An operation is started
// with start and reported by a one-cycle done pulse, together with the sum,
// carry-out and signed overflow.
//
// Handshake: start is sampled only when the block is not busy (IDLE or
// DONE); an operation accepted at edge T0 produces done=1 in the cycle after
// edge T0+WIDTH, with Sum/Cout/Overflow valid in that same cycle. start
// while busy=1 is ignored.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             Mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic            carry;

    logic            accept;
    logic            s_bit;
    logic            c_next;
    logic [WIDTH-1:0] r_next;

    // Full-adder cell on the operand LSBs, the accept decode, and the
    // result register as it will look after this edge's shift.
    always_comb begin
        accept = 1'b0;
        s_bit  = 1'b0;
        c_next = 1'b0;
        r_next = '0;
        accept = start && (state == IDLE || state == DONE);
        s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
        c_next = (a_sr[0] & b_sr[0]) | (b_sr[0] & carry) | (carry & a_sr[0]);
        r_next = {s_bit, r_sr[WIDTH-1:1]};
    end

    // Control FSM and serial datapath. Subtract is folded into the operand
    // load (~B, carry=1), so Mode only matters on the accepting edge and
    // later changes to it cannot affect an operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            r_sr     <= '0;
            carry    <= 1'b0;
            Sum      <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a_sr  <= A;
                        b_sr  <= Mode ? ~B : B;
                        carry <= Mode ? 1'b1 : Cin;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    r_sr  <= r_next;
                    carry <= c_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // carry still holds the carry into the MSB here
                        Sum      <= r_next;
                        Cout     <= c_next;
                        Overflow <= carry ^ c_next;
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor: the multi-cycle successor to the single-bit full adder. It processes one bit per clock, LSB first, through a single full-adder cell and a registered carry. It trades latency for area in datapaths where operand width is large and throughput demand is low. Operations are started and completed through a start/done handshake, and the block reports sum, carry-out and signed overflow.

## Interface

- WIDTH, 8: operand and result width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- Mode  input  1  0 = add (A + B + Cin), 1 = subtract (A - B, computed as A + ~B + 1; Cin ignored).
- A  input  WIDTH  operand A; sampled on the accepting edge.
- B  input  WIDTH  operand B; sampled on the accepting edge.
- Cin  input  1  carry-in for add; sampled on the accepting edge.
- Sum  output  WIDTH  registered result.
- Cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- Overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when Sum/Cout/Overflow update.

## Operation

- Three states:
  - IDLE: waiting for start.
  - RUN: one bit per cycle.
  - DONE: single cycle with done=1.
- Transitions:
  - IDLE→RUN on start=1.
  - RUN→RUN while bit counter < WIDTH-1.
  - RUN→DONE on the edge that processes bit WIDTH-1.
  - DONE→RUN if start=1, otherwise DONE→IDLE.
- Accepting edge:
  - load the A shift register with A.
  - load the B shift register with B, or ~B when Mode=1.
  - load the carry register with Cin, or 1 when Mode=1.
  - clear the bit counter, which is $clog2(WIDTH) bits wide.
  - latch Mode internally; Mode changes during RUN have no effect.
- Each RUN edge:
  - s = a0 ^ b0 ^ c; c' = a0&b0 | b0&c | c&a0 on the LSBs of the A and B shift registers.
  - shift both operand registers right by 1.
  - shift s into the MSB of the result shift register.
  - update carry; increment counter.
  - on the bit WIDTH-1 edge, also capture the carry into MSB for overflow.
- Entering DONE:
  - Sum ← completed result shift register.
  - Cout ← final carry.
  - Overflow ← carry-into-MSB ^ final carry.
- Sum, Cout and Overflow hold their previous values throughout RUN, and hold after DONE until the next completion.
- start while busy=1 is ignored and has no side effects.
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, all shift registers, counter and carry = 0.
  - Sum=0, Cout=0, Overflow=0, busy=0, done=0.
  - An operation in progress is discarded and produces no done.

## Timing

- Latency: start accepted at edge T0; done=1 in the cycle following edge T0+WIDTH; results valid in that same cycle.
- busy=1 from after edge T0 through edge T0+WIDTH-1 (exactly WIDTH cycles); busy=0 in the DONE cycle.
- Back-to-back: start=1 during the DONE cycle is accepted at that edge, giving a throughput of one result per WIDTH+1 cycles.
- done is never high for more than one consecutive cycle.
- Outputs are fully registered; there is no combinational path from inputs to outputs.
- Reset release is synchronous to the design only via the clock. The first start is accepted on the first rising edge with rst_n=1 and start=1.

## Test plan

- Reset: hold rst_n=0 with random inputs and clocks toggling → Sum=0, Cout=0, Overflow=0, busy=0, done=0 throughout; no done after release without start.
- Add carry-out, WIDTH=8: A=8'hFF, B=8'h01, Cin=0, Mode=0 → done exactly 8 cycles after the accepting edge (9th cycle), Sum=8'h00, Cout=1, Overflow=0. With Cin=1 → Sum=8'h01, Cout=1.
- Signed overflow add: A=8'h7F, B=8'h01, Cin=0 → Sum=8'h80, Cout=0, Overflow=1.
- Subtract:
  - A=8'h05, B=8'h07, Mode=1, Cin=1 → Sum=8'hFE, Cout=0, Overflow=0 (Cin ignored).
  - A=8'h80, B=8'h01 → Sum=8'h7F, Cout=1, Overflow=1.
- Handshake:
  - start pulses at cycles 2 and 5 of RUN → ignored; Sum keeps the previous result until done.
  - start held high in the DONE cycle with A=8'h10, B=8'h20 → new op accepted; next done after WIDTH more cycles with Sum=8'h30.
- Reset mid-operation: assert rst_n=0 after 4 RUN cycles → immediate IDLE with all outputs 0 and no done. After release, A=8'hAA, B=8'h55, Cin=1 → Sum=8'h00, Cout=1, Overflow=0.
